multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 116 +++++++++++
 tb/tb_multicycle_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS-style datapath.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
    BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t r_state, w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= FETCH;
    else r_state <= w_next;
  assign state = r_state;
  // Outputs are gated by rst_n so they read 0 for the whole reset, not only after the state clears.
  always_comb begin
    w_next = FETCH;
    pc_write = 1'b0;
    ir_write = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_op = 2'd0;
    pc_src = 2'd0;
    illegal = 1'b0;
    if (rst_n)
      case (r_state)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'd1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          w_next = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'd3;
          case (op)
            6'b000000: w_next = EXEC;
            6'b100011, 6'b101011: w_next = MEMADR;
            6'b000100: w_next = BRANCH;
            6'b001000: w_next = ADDIEX;
            6'b000010: w_next = JUMP;
            default: illegal = 1'b1;
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          w_next = (op == 6'b100011) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_read = 1'b1;
          i_or_d = 1'b1;
          w_next = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          i_or_d = 1'b1;
          w_next = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op = 2'd2;
          w_next = ALUWB;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = 2'd1;
          pc_src = 2'd1;
          pc_write = zero;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          w_next = ADDIWB;
        end
        ADDIWB: reg_write = 1'b1;
        JUMP: begin
          pc_write = 1'b1;
          pc_src = 2'd2;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction mix checked against per-instruction expected cycle traces.
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'd0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [15:0] obs;
  int checks = 0, failures = 0;

  localparam logic [15:0] PCW = 16'h8000, IRW = 16'h4000, IORD = 16'h2000, MRD = 16'h1000,
    MWR = 16'h0800, M2R = 16'h0400, RDST = 16'h0200, RW = 16'h0100, ASA = 16'h0080, ILL = 16'h0001;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  typedef struct packed {logic [5:0] op; logic mr; logic z; logic [3:0] st; logic [15:0] o;} cyc_t;
  cyc_t q[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;
  assign obs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, illegal};

  function automatic logic [15:0] asb(input int v); return 16'(v) << 5; endfunction
  function automatic logic [15:0] aop(input int v); return 16'(v) << 3; endfunction
  function automatic logic [15:0] psrc(input int v); return 16'(v) << 1; endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [5:0] o, input logic mr, input logic z, input int st, input logic [15:0] w);
    q.push_back('{op: o, mr: mr, z: z, st: 4'(st), o: w});
  endtask

  // Expected cycle-by-cycle trace of one instruction; fw/mw = stall cycles on fetch/data memory.
  task automatic build(input logic [5:0] o, input int fw, input int mw, input logic z);
    logic legal;
    legal = o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    for (int i = 0; i < fw; i++) push(o, 1'b0, 1'($urandom), 0, MRD | asb(1));
    push(o, 1'b1, 1'($urandom), 0, PCW | IRW | MRD | asb(1));
    push(o, 1'($urandom), 1'($urandom), 1, asb(3) | (legal ? 16'h0 : ILL));
    case (o)
      OP_R: begin
        push(o, 1'($urandom), 1'($urandom), 6, ASA | aop(2));
        push(o, 1'($urandom), 1'($urandom), 7, RW | RDST);
      end
      OP_LW, OP_SW: begin
        push(o, 1'($urandom), 1'($urandom), 2, ASA | asb(2));
        for (int i = 0; i <= mw; i++)
          push(o, i == mw, 1'($urandom), o == OP_LW ? 3 : 5, IORD | (o == OP_LW ? MRD : MWR));
        if (o == OP_LW) push(o, 1'($urandom), 1'($urandom), 4, RW | M2R);
      end
      OP_BEQ: push(o, 1'($urandom), z, 8, ASA | aop(1) | psrc(1) | (z ? PCW : 16'h0));
      OP_ADDI: begin
        push(o, 1'($urandom), 1'($urandom), 9, ASA | asb(2));
        push(o, 1'($urandom), 1'($urandom), 10, RW);
      end
      OP_J: push(o, 1'($urandom), 1'($urandom), 11, PCW | psrc(2));
      default: ;
    endcase
  endtask

  task automatic run_q();
    cyc_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      op = e.op;
      mem_ready = e.mr;
      zero = e.z;
      #1;
      check("state", 16'(state), 16'(e.st));
      check("outs", obs, e.o);
      check("mem_excl", 16'(mem_read & mem_write), 16'h0);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input logic z);
    build(o, fw, mw, z);
    run_q();
  endtask

  // Abort an access while it waits on memory; nothing may remain asserted during reset.
  task automatic reset_during(input logic [5:0] o);
    build(o, 0, 6, 1'b0);
    while (q.size() > 5) void'(q.pop_back());
    run_q();
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 16'(state), 16'h0);
    check("rst_outs", obs, 16'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_hold", obs, 16'h0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_rel", obs, MRD | asb(1));
  endtask

  initial begin
    logic [5:0] o;
    logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    #1;
    check("por_state", 16'(state), 16'h0);
    check("por_outs", obs, 16'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("por_hold", obs, 16'h0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("por_rel", obs, MRD | asb(1));
    run_instr(OP_LW, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_R, 2, 0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    reset_during(OP_LW);
    reset_during(OP_SW);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 6) == 0)
        do o = 6'($urandom); while (o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      else o = ops[$urandom_range(0, 5)];
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
